// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction field positions and immediate-extension helper
// for the decode stage.
package decode_pkg;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_ANDI  = 6'h0C;
    localparam opcode_t OP_ORI   = 6'h0D;
    localparam opcode_t OP_XORI  = 6'h0E;

    localparam int OP_LSB  = 26;
    localparam int OP_W    = 6;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

    // Logical immediates are zero-extended; everything else is sign-extended.
    function automatic logic is_zext_op(input opcode_t op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// Bundle of the decode stage's instruction handshake, decoded-output handshake and
// writeback port.
interface decode_pipe_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    // valid/ready: a transfer happens on a rising edge where both are 1; a source
    // holding valid keeps its payload stable until that edge.
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     ir_i;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] Imm;
    logic [AW-1:0]   rd_o;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    modport master (
        output in_valid, ir_i, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, op, A, B, Imm, rd_o
    );

    modport slave (
        input  in_valid, ir_i, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, op, A, B, Imm, rd_o
    );

endinterface

// File: rtl/decode_regfile.sv
// Register file: two async read ports, one sync write port, r0 hardwired to zero.
// DECODE_BYPASS_EN makes a same-cycle write visible on the read ports.
module decode_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra_addr,
    output logic [XLEN-1:0] ra_data,
    input  logic [AW-1:0]   rb_addr,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        ra_data = mem[ra_addr];
        rb_data = mem[rb_addr];
`ifdef DECODE_BYPASS_EN
        if (we && (waddr == ra_addr)) ra_data = wdata;
        if (we && (waddr == rb_addr)) rb_data = wdata;
`endif
        if (ra_addr == '0) ra_data = '0;
        if (rb_addr == '0) rb_data = '0;
    end

endmodule

// File: rtl/decode_pipe.sv
// Single-entry decode stage with operand fetch and stale-operand refresh while stalled.
// Optional build macro DECODE_BYPASS_EN enables regfile write-through.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic         clk,
    input logic         rst,
    decode_pipe_if.slave bus
);

    localparam int AW = $clog2(NREG);

    logic [5:0]      ir_op;
    logic [AW-1:0]   ir_rs, ir_rt, ir_rd;
    logic [15:0]     ir_imm;
    logic [XLEN-1:0] imm_d;

    logic            out_valid_q;
    logic [5:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, imm_q;
    logic [AW-1:0]   rd_q, rs_q, rt_q;
    logic            pend_a_q, pend_b_q;

    logic            stall, accept;
    logic            hit_a, hit_b, refresh_a, refresh_b;
    logic [AW-1:0]   ra_addr, rb_addr;
    logic [XLEN-1:0] ra_data, rb_data;

    assign ir_op  = bus.ir_i[OP_LSB +: OP_W];
    assign ir_rs  = bus.ir_i[RS_LSB +: AW];
    assign ir_rt  = bus.ir_i[RT_LSB +: AW];
    assign ir_rd  = bus.ir_i[RD_LSB +: AW];
    assign ir_imm = bus.ir_i[IMM_LSB +: IMM_W];

    assign imm_d = is_zext_op(ir_op) ? {{(XLEN-16){1'b0}}, ir_imm}
                                     : {{(XLEN-16){ir_imm[15]}}, ir_imm};

    assign stall  = out_valid_q && !bus.out_ready;
    assign accept = bus.in_valid && !stall;

    // While stalled the read ports watch the held source registers.
    assign ra_addr = stall ? rs_q : ir_rs;
    assign rb_addr = stall ? rt_q : ir_rt;

    assign hit_a = bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == rs_q);
    assign hit_b = bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == rt_q);

    // Without write-through, the write-cycle read sees the old value, so a hit is
    // re-read one cycle later once the regfile holds the new data.
    assign refresh_a = stall && (hit_a || pend_a_q);
    assign refresh_b = stall && (hit_b || pend_b_q);

    decode_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (ra_addr),
        .ra_data (ra_data),
        .rb_addr (rb_addr),
        .rb_data (rb_data),
        .we      (bus.wb_en),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            pend_a_q    <= 1'b0;
            pend_b_q    <= 1'b0;
        end else begin
            pend_a_q <= stall && hit_a;
            pend_b_q <= stall && hit_b;
            if (accept) begin
                out_valid_q <= 1'b1;
                op_q        <= ir_op;
                a_q         <= ra_data;
                b_q         <= rb_data;
                imm_q       <= imm_d;
                rd_q        <= (ir_op == OP_RTYPE) ? ir_rd : ir_rt;
                rs_q        <= ir_rs;
                rt_q        <= ir_rt;
            end else begin
                if (bus.out_ready) out_valid_q <= 1'b0;
                if (refresh_a) a_q <= ra_data;
                if (refresh_b) b_q <= rb_data;
            end
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = out_valid_q;
    assign bus.op        = op_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.Imm       = imm_q;
    assign bus.rd_o      = rd_q;

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter: XLEN, default 32, width of operands and immediate (legal 32 or 64).
REQ-002 Parameter: NREG, default 32, register count, power of two, 2..32; AW = clog2(NREG).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  ir_i holds an instruction.
REQ-006 in_ready  output  1  stage accepts ir_i this cycle.
REQ-007 ir_i  input  32  instruction; op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
REQ-008 out_valid  output  1  decoded outputs valid.
REQ-009 out_ready  input  1  downstream accepts outputs.
REQ-010 op  output  6  registered opcode.
REQ-011 A, B  output  XLEN each  registered operands read from rs, rt.
REQ-012 Imm  output  XLEN  registered extended immediate.
REQ-013 rd_o  output  AW  registered destination: rd if op==0, else rt.
REQ-014 wb_en, wb_addr[AW-1:0], wb_data[XLEN-1:0]  inputs  writeback port (generalises the old reg_update/reg_i).

Function
REQ-015 Register-index fields SHALL use their low AW bits.
REQ-016 Register 0 SHALL read as zero; writes to it SHALL be ignored.
REQ-017 wb_en=1 SHALL write wb_data to wb_addr at the clock edge, independent of handshake state.
REQ-018 in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-019 On in_valid && in_ready, outputs SHALL load the decode of ir_i at the next edge; latency 1 cycle.
REQ-020 out_valid SHALL set on accept, clear when out_ready && !in_valid, and stay 1 under back-to-back accepts.
REQ-021 While out_valid && !out_ready, op/Imm/rd_o SHALL hold; A or B SHALL reload if wb_en targets the held rs or rt (stale-operand refresh).
REQ-022 Imm SHALL be zero-extended for op 0x0C, 0x0D, 0x0E and sign-extended to XLEN otherwise.
REQ-023 Without accept and without refresh, all outputs SHALL hold.

Reset
REQ-024 rst SHALL clear out_valid, op, A, B, Imm, rd_o and every register to 0 in one cycle.
REQ-025 rst SHALL override a simultaneous accept or writeback; in_ready SHALL read 1 in the cycle after reset.

Configuration
REQ-026 Macro DECODE_BYPASS_EN defined: a read of wb_addr in the cycle wb_en=1 SHALL return wb_data (write-through) for accept and refresh.
REQ-027 Macro undefined: such a read SHALL return the pre-write value; the writer must insert a gap cycle.

Structure
REQ-028 Package decode_pkg SHALL hold opcode constants (OP_RTYPE=0, OP_ANDI=0x0C, OP_ORI=0x0D, OP_XORI=0x0E) and instruction field bit positions.
REQ-029 Register file SHALL be sub-module decode_regfile (2 async read ports, 1 sync write port, bypass under DECODE_BYPASS_EN).

Verification
REQ-030 Reset, then ir_i=0x00000800, in_valid=1, out_ready=1 -> next cycle out_valid=1, op=0, rd_o=1, A=B=0, Imm=0x00000800.
REQ-031 wb writes r4=0x4, then ir_i=0x8C850010 -> op=0x23, A=0x4, Imm=0x10, rd_o=5; ir_i imm=0xFFFC (op 0x08) -> Imm=0xFFFFFFFC; op 0x0D imm=0xFFFC -> Imm=0x0000FFFC.
REQ-032 Hold out_ready=0 with rs=3 in output, write r3=0x55 -> A becomes 0x55 next cycle, op/Imm unchanged, in_ready=0.
REQ-033 Same-cycle write r2=0x9 and accept reading r2 -> A=0x9 with DECODE_BYPASS_EN, old value without it.
REQ-034 Write r0=0xFF, then read r0 -> A=0; assert rst mid-stall -> out_valid=0, all registers 0, next accept proceeds normally.
